// File: rtl/time_keeper_pkg.sv
// time_keeper_pkg
//   Shared constants, types and helpers for the time_keeper block.
//   - SEC_MAX / MIN_MAX / HOUR_MAX : terminal counts of the three time counters
//   - tk_state_e                   : control FSM state encoding
//   - tk_time_t                    : binary hh:mm:ss bundle used for load values
//   - bin2bcd()                    : two-digit binary-to-BCD conversion (0..99)
package time_keeper_pkg;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } tk_state_e;

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
  } tk_time_t;

  // Repeated subtraction of ten; the loop is fully unrolled into a small
  // comparator/subtractor chain, which is all that two-digit values need.
  function automatic logic [7:0] bin2bcd(input logic [6:0] bin);
    logic [3:0] tens;
    logic [6:0] rem;
    tens = 4'd0;
    rem  = bin;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, 4'(rem)};
  endfunction

endpackage

// File: rtl/time_keeper_if.sv
// time_keeper_if
//   Load-request handshake between a time setter and time_keeper.
//   - set_valid                  : load request (master -> slave)
//   - set_hour / set_min / set_sec : binary load values (master -> slave)
//   - set_ready                  : request can be accepted this cycle (slave -> master)
//   - set_err                    : one-cycle pulse, out-of-range load rejected (slave -> master)
interface time_keeper_if;

  logic       set_valid;
  logic       set_ready;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic [5:0] set_sec;
  logic       set_err;

  modport master (
    output set_valid, set_hour, set_min, set_sec,
    input  set_ready, set_err
  );

  modport slave (
    input  set_valid, set_hour, set_min, set_sec,
    output set_ready, set_err
  );

endinterface

// File: rtl/time_keeper_mod_counter.sv
// mod_counter
//   Modulo-(MAX+1) binary counter with synchronous load; instances are
//   chained by feeding one counter's wrap into the next counter's inc.
//   - clk, rst_n : clock, asynchronous active-low reset (value -> 0)
//   - inc        : advance by one this cycle
//   - load       : replace value with load_val (takes priority over inc)
//   - load_val   : value to load; caller guarantees load_val <= MAX
//   - value      : current count
//   - wrap       : combinational, high when an inc takes MAX back to 0
module mod_counter #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         wrap
);

  logic [W-1:0] value_q, value_d;
  logic         at_max;

  assign at_max = (value_q == W'(MAX));
  assign wrap   = inc & ~load & at_max;
  assign value  = value_q;

  always_comb begin
    // NOTE: default assignment first so every path through the block drives
    // value_d; a missing else branch would otherwise infer a latch.
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (inc) begin
      value_d = at_max ? '0 : value_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/time_keeper.sv
// time_keeper
//   Time-of-day counter advanced by an external 1 Hz square wave, with a
//   validated load port and BCD outputs.
//   - clk_100M      : system clock, all logic on rising edge
//   - sys_rst_n     : asynchronous active-low reset
//   - clk_1Hz_in    : asynchronous 1 Hz square wave; each rising edge is one second
//   - run_en        : 1 = count seconds, 0 = hold time
//   - set_if        : load handshake (set_valid/set_ready/set_hour/min/sec/set_err)
//   - hour_bcd / min_bcd / sec_bcd : two-digit BCD time, tens in [7:4]
//   - pm            : high for hours 12..23
//   - sec_tick      : one-cycle pulse per counted second
//   - day_wrap      : one-cycle pulse on 23:59:59 -> 00:00:00
//   TWELVE_HOUR = 1 shows hour_bcd as 12, 01..11 instead of 00..23.
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter bit TWELVE_HOUR = 1'b0
) (
  input  logic         clk_100M,
  input  logic         sys_rst_n,
  input  logic         clk_1Hz_in,
  input  logic         run_en,
  time_keeper_if.slave set_if,
  output logic [7:0]   hour_bcd,
  output logic [7:0]   min_bcd,
  output logic [7:0]   sec_bcd,
  output logic         pm,
  output logic         sec_tick,
  output logic         day_wrap
);

  // ---------------------------------------------------------------------------
  // 1 Hz input: sync_q[0..1] is the two-flop synchronizer, sync_q[2] holds the
  // previous synchronized sample for edge detection. fill_q marks when all
  // three stages hold real samples, so a clk_1Hz_in that is already high when
  // reset is released does not look like a fresh rising edge.
  // ---------------------------------------------------------------------------
  logic [2:0] sync_q, sync_d;
  logic [2:0] fill_q, fill_d;
  logic       tick;

  always_comb begin
    sync_d = {sync_q[1:0], clk_1Hz_in};
    fill_d = {fill_q[1:0], 1'b1};
  end

  always_ff @(posedge clk_100M or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q <= sync_d;
      fill_q <= fill_d;
    end
  end

  // High for one cycle, two edges after the input rises; the counters and
  // sec_tick register it on the third edge.
  assign tick = sync_q[1] & ~sync_q[2] & fill_q[2];

  // ---------------------------------------------------------------------------
  // Control FSM with registered handshake/status outputs.
  // ---------------------------------------------------------------------------
  tk_state_e  state_q, state_d;
  tk_time_t   load_q, load_d;
  logic       load_ok_q, load_ok_d;
  logic       set_ready_q, set_ready_d;
  logic       set_err_q, set_err_d;
  logic       sec_tick_q, sec_tick_d;
  logic       day_wrap_q, day_wrap_d;

  logic       in_range, accept, inc_sec, do_load;
  logic       sec_wrap, min_wrap, hour_wrap;
  logic [5:0] sec_val, min_val;
  logic [4:0] hour_val;

  assign in_range = (set_if.set_hour <= 5'(HOUR_MAX)) &&
                    (set_if.set_min  <= 6'(MIN_MAX))  &&
                    (set_if.set_sec  <= 6'(SEC_MAX));
  assign accept   = set_if.set_valid & set_ready_q;
  // A tick arriving with an accepted load (or during LOAD) is dropped so the
  // loaded value is exactly what appears afterwards.
  assign inc_sec  = tick & (state_q == ST_RUN) & ~accept;
  assign do_load  = (state_q == ST_LOAD) & load_ok_q;

  always_comb begin
    state_d     = state_q;
    load_d      = load_q;
    load_ok_d   = 1'b0;
    set_ready_d = 1'b1;
    set_err_d   = 1'b0;
    sec_tick_d  = inc_sec;
    day_wrap_d  = hour_wrap;
    case (state_q)
      ST_HOLD, ST_RUN: begin
        if (accept) begin
          state_d     = ST_LOAD;
          load_d      = '{hour: set_if.set_hour, min: set_if.set_min, sec: set_if.set_sec};
          load_ok_d   = in_range;
          set_ready_d = 1'b0;
          set_err_d   = ~in_range;
        end else begin
          state_d = run_en ? ST_RUN : ST_HOLD;
        end
      end
      ST_LOAD: state_d = run_en ? ST_RUN : ST_HOLD;
      default: state_d = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk_100M or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_HOLD;
      load_q      <= '0;
      load_ok_q   <= 1'b0;
      set_ready_q <= 1'b0;
      set_err_q   <= 1'b0;
      sec_tick_q  <= 1'b0;
      day_wrap_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      load_ok_q   <= load_ok_d;
      set_ready_q <= set_ready_d;
      set_err_q   <= set_err_d;
      sec_tick_q  <= sec_tick_d;
      day_wrap_q  <= day_wrap_d;
    end
  end

  assign set_if.set_ready = set_ready_q;
  assign set_if.set_err   = set_err_q;
  assign sec_tick         = sec_tick_q;
  assign day_wrap         = day_wrap_q;

  // ---------------------------------------------------------------------------
  // Time counters: sec -> min -> hour chained through wrap.
  // ---------------------------------------------------------------------------
  mod_counter #(.W(6), .MAX(SEC_MAX)) u_sec (
    .clk      (clk_100M),
    .rst_n    (sys_rst_n),
    .inc      (inc_sec),
    .load     (do_load),
    .load_val (load_q.sec),
    .value    (sec_val),
    .wrap     (sec_wrap)
  );

  mod_counter #(.W(6), .MAX(MIN_MAX)) u_min (
    .clk      (clk_100M),
    .rst_n    (sys_rst_n),
    .inc      (sec_wrap),
    .load     (do_load),
    .load_val (load_q.min),
    .value    (min_val),
    .wrap     (min_wrap)
  );

  mod_counter #(.W(5), .MAX(HOUR_MAX)) u_hour (
    .clk      (clk_100M),
    .rst_n    (sys_rst_n),
    .inc      (min_wrap),
    .load     (do_load),
    .load_val (load_q.hour),
    .value    (hour_val),
    .wrap     (hour_wrap)
  );

  // ---------------------------------------------------------------------------
  // Display encoding, combinational from the counter registers.
  // ---------------------------------------------------------------------------
  logic [4:0] hour_disp;

  always_comb begin
    hour_disp = hour_val;
    if (TWELVE_HOUR) begin
      if (hour_val == 5'd0) begin
        hour_disp = 5'd12;
      end else if (hour_val > 5'd12) begin
        hour_disp = hour_val - 5'd12;
      end
    end
  end

  assign hour_bcd = bin2bcd(7'(hour_disp));
  assign min_bcd  = bin2bcd(7'(min_val));
  assign sec_bcd  = bin2bcd(7'(sec_val));
  assign pm       = (hour_val >= 5'd12);

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper
//   Drives a 24-hour and a 12-hour time_keeper with identical stimulus and
//   compares both against a seconds-of-day reference model.
`timescale 1ns/1ps
module tb_time_keeper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_1hz = 1'b0;
  logic       run_en = 1'b0;
  logic       set_valid = 1'b0;
  logic [4:0] set_hour = '0;
  logic [5:0] set_min = '0;
  logic [5:0] set_sec = '0;

  logic [7:0] h24, m24, s24, h12, m12, s12;
  logic       pm24, tick24, wrap24, pm12, tick12, wrap12;

  always #5 clk = ~clk;

  time_keeper_if if24 ();
  time_keeper_if if12 ();

  assign if24.set_valid = set_valid;
  assign if24.set_hour  = set_hour;
  assign if24.set_min   = set_min;
  assign if24.set_sec   = set_sec;
  assign if12.set_valid = set_valid;
  assign if12.set_hour  = set_hour;
  assign if12.set_min   = set_min;
  assign if12.set_sec   = set_sec;

  time_keeper #(.TWELVE_HOUR(1'b0)) dut24 (
    .clk_100M (clk), .sys_rst_n (rst_n), .clk_1Hz_in (clk_1hz), .run_en (run_en),
    .set_if (if24.slave),
    .hour_bcd (h24), .min_bcd (m24), .sec_bcd (s24),
    .pm (pm24), .sec_tick (tick24), .day_wrap (wrap24)
  );

  time_keeper #(.TWELVE_HOUR(1'b1)) dut12 (
    .clk_100M (clk), .sys_rst_n (rst_n), .clk_1Hz_in (clk_1hz), .run_en (run_en),
    .set_if (if12.slave),
    .hour_bcd (h12), .min_bcd (m12), .sec_bcd (s12),
    .pm (pm12), .sec_tick (tick12), .day_wrap (wrap12)
  );

  int vectors = 0;
  int miscompares = 0;
  int ref_tod = 0;   // reference time as seconds since midnight

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  function automatic int disp12(input int h);
    return (h % 12 == 0) ? 12 : h % 12;
  endfunction

  task automatic check_time(input string tag);
    int h, m, s;
    h = ref_tod / 3600;
    m = (ref_tod / 60) % 60;
    s = ref_tod % 60;
    check({tag, ".h24"},  h24, bcd(h));
    check({tag, ".ms24"}, {m24, s24}, (bcd(m) << 8) | bcd(s));
    check({tag, ".pm24"}, pm24, (h >= 12));
    check({tag, ".h12"},  h12, bcd(disp12(h)));
    check({tag, ".ms12"}, {m12, s12}, (bcd(m) << 8) | bcd(s));
    check({tag, ".pm12"}, pm12, (h >= 12));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One rising edge on clk_1Hz_in; entered and left just after a negedge.
  task automatic one_tick(input bit counted);
    clk_1hz = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("tick.early", tick24, 1'b0);
    end
    @(negedge clk);
    if (counted) ref_tod = (ref_tod + 1) % 86400;
    check("tick.sec_tick24", tick24, counted);
    check("tick.sec_tick12", tick12, counted);
    check("tick.day_wrap24", wrap24, counted && ref_tod == 0);
    check("tick.day_wrap12", wrap12, counted && ref_tod == 0);
    check_time("tick");
    @(negedge clk);
    check("tick.pulse_len", {tick24, wrap24, tick12, wrap12}, 4'b0000);
    clk_1hz = 1'b0;
    cycles(3);
  endtask

  task automatic do_load(input int h, input int m, input int s);
    bit ok;
    ok = (h <= 23) && (m <= 59) && (s <= 59);
    check("load.ready_before", {if24.set_ready, if12.set_ready}, 2'b11);
    set_valid = 1'b1;
    set_hour  = 5'(h);
    set_min   = 6'(m);
    set_sec   = 6'(s);
    @(negedge clk);
    set_valid = 1'b0;
    check("load.ready_in_load", {if24.set_ready, if12.set_ready}, 2'b00);
    check("load.err", {if24.set_err, if12.set_err}, ok ? 2'b00 : 2'b11);
    check_time("load.pre");
    @(negedge clk);
    if (ok) ref_tod = h * 3600 + m * 60 + s;
    check("load.ready_after", {if24.set_ready, if12.set_ready}, 2'b11);
    check("load.err_len", {if24.set_err, if12.set_err}, 2'b00);
    check_time("load.post");
  endtask

  initial begin
    int op, h, m, s;

    // Reset with clk_1Hz_in already high and run_en set.
    clk_1hz = 1'b1;
    run_en  = 1'b1;
    cycles(3);
    check("rst.ready", {if24.set_ready, if12.set_ready}, 2'b00);
    check("rst.pulses", {tick24, wrap24, if24.set_err, tick12, wrap12, if12.set_err}, 6'b0);
    check_time("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.ready_first_edge", {if24.set_ready, if12.set_ready}, 2'b11);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst.no_spurious_tick", {tick24, tick12}, 2'b00);
    end
    check_time("rst.held_high");
    clk_1hz = 1'b0;
    cycles(3);

    // Three seconds counted.
    for (int i = 0; i < 3; i++) one_tick(1'b1);
    check("three_ticks.sec", s24, 8'h03);

    // Day wrap with pm falling.
    do_load(23, 59, 58);
    one_tick(1'b1);
    check("wrap.pm_before", {h24, m24, s24, pm24}, {24'h235959, 1'b1});
    one_tick(1'b1);
    check("wrap.pm_after", {h24, m24, s24, pm24}, {24'h000000, 1'b0});

    // Out-of-range loads rejected.
    do_load(24, 0, 0);
    do_load(5, 60, 0);
    do_load(0, 0, 60);
    do_load(31, 63, 63);

    // Holding discards ticks; resuming counts exactly one.
    do_load(8, 30, 15);
    run_en = 1'b0;
    cycles(2);
    for (int i = 0; i < 5; i++) one_tick(1'b0);
    run_en = 1'b1;
    cycles(2);
    one_tick(1'b1);
    check("hold.resume", {h24, m24, s24}, 24'h083016);

    // Tick coinciding with load acceptance.
    clk_1hz = 1'b1;
    cycles(2);
    set_valid = 1'b1; set_hour = 5'd10; set_min = 6'd0; set_sec = 6'd0;
    @(negedge clk);
    set_valid = 1'b0;
    check("coincide.accept_tick", {tick24, tick12}, 2'b00);
    @(negedge clk);
    ref_tod = 10 * 3600;
    check("coincide.load_tick", {tick24, tick12}, 2'b00);
    check_time("coincide");
    check("coincide.value", {h24, m24, s24}, 24'h100000);
    clk_1hz = 1'b0;
    cycles(3);

    // Tick landing in the LOAD cycle.
    clk_1hz = 1'b1;
    @(negedge clk);
    set_valid = 1'b1; set_hour = 5'd11; set_min = 6'd22; set_sec = 6'd33;
    @(negedge clk);
    set_valid = 1'b0;
    @(negedge clk);
    ref_tod = 11 * 3600 + 22 * 60 + 33;
    check("loadcyc.tick", {tick24, tick12}, 2'b00);
    check_time("loadcyc");
    clk_1hz = 1'b0;
    cycles(3);

    // 12-hour display corner cases.
    do_load(0, 0, 0);
    check("h12.midnight", {h12, pm12}, {8'h12, 1'b0});
    do_load(13, 5, 0);
    check("h12.afternoon", {h12, pm12}, {8'h01, 1'b1});
    do_load(12, 0, 0);
    check("h12.noon", {h12, pm12}, {8'h12, 1'b1});

    // Reset during the LOAD cycle aborts the load.
    do_load(7, 7, 7);
    set_valid = 1'b1; set_hour = 5'd12; set_min = 6'd34; set_sec = 6'd56;
    @(negedge clk);
    set_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    ref_tod = 0;
    check("midload.ready", {if24.set_ready, if12.set_ready}, 2'b00);
    check("midload.err", {if24.set_err, if12.set_err}, 2'b00);
    check_time("midload");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midload.ready_after", {if24.set_ready, if12.set_ready}, 2'b11);
    check_time("midload.after");
    cycles(3);

    // Randomized operations against the reference model.
    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 6));
      if (op <= 2) begin
        one_tick(run_en);
      end else if (op <= 4) begin
        h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(22, 25)) : int'($urandom_range(0, 23));
        m = ($urandom_range(0, 1) == 0) ? int'($urandom_range(58, 61)) : int'($urandom_range(0, 59));
        s = ($urandom_range(0, 1) == 0) ? int'($urandom_range(57, 60)) : int'($urandom_range(0, 59));
        do_load(h, m, s);
      end else if (op == 5) begin
        run_en = ($urandom_range(0, 3) != 0);
        cycles(2);
      end else begin
        cycles(int'($urandom_range(1, 10)));
        check_time("rand.idle");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 Parameter: TWELVE_HOUR, default 0, 1 selects 12-hour display encoding (01..12 with pm flag), 0 selects 24-hour (00..23).
REQ-002 Port: clk_100M  input  1  100 MHz system clock, all logic on rising edge.
REQ-003 Port: sys_rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: clk_1Hz_in  input  1  square wave from the divider, toggling every 50,000,000 cycles; treated as asynchronous.
REQ-005 Port: run_en  input  1  1 = count seconds, 0 = hold time.
REQ-006 Port: set_valid  input  1  load request.
REQ-007 Port: set_ready  output  1  load can be accepted this cycle.
REQ-008 Port: set_hour / set_min / set_sec  input  5/6/6  binary load values.
REQ-009 Port: set_err  output  1  one-cycle pulse, out-of-range load rejected.
REQ-010 Port: hour_bcd / min_bcd / sec_bcd  output  8 each  two-digit BCD time, tens in [7:4].
REQ-011 Port: pm  output  1  high for hours 12..23; valid in both modes.
REQ-012 Port: sec_tick  output  1  one-cycle pulse per counted second.
REQ-013 Port: day_wrap  output  1  one-cycle pulse on 23:59:59 -> 00:00:00.

Function
REQ-014 clk_1Hz_in SHALL pass through a 2-flop synchronizer, then a rising-edge detector; the internal tick asserts exactly 3 clk_100M cycles after the input rises and lasts 1 cycle.
REQ-015 FSM states: HOLD (run_en=0), RUN (run_en=1), LOAD (one cycle); HOLD<->RUN follows run_en on the next edge; either state -> LOAD on set_valid && set_ready; LOAD -> RUN if run_en else HOLD.
REQ-016 set_ready SHALL be 1 in HOLD and RUN, 0 in LOAD.
REQ-017 Accepted load with set_hour<=23, set_min<=59, set_sec<=59 SHALL update outputs in the LOAD cycle + 1 (outputs visible 2 edges after acceptance).
REQ-018 Out-of-range load SHALL leave time unchanged and pulse set_err for 1 cycle in the LOAD state.
REQ-019 In RUN, each internal tick SHALL increment seconds; sec_tick SHALL pulse in the same cycle the seconds register updates.
REQ-020 sec 59 -> 00 with min+1; min 59 -> 00 with hour+1; hour 23 -> 00 with day_wrap pulse, coincident with sec_tick.
REQ-021 In HOLD, ticks SHALL be discarded; no catch-up after resuming.
REQ-022 A tick coinciding with load acceptance or the LOAD cycle SHALL be discarded; the loaded value wins.
REQ-023 Counters SHALL hold binary internally; BCD conversion SHALL be combinational from registers, so there is no added output latency.
REQ-024 TWELVE_HOUR=1: hour_bcd maps 0 -> 12, 13..23 -> 1..11; TWELVE_HOUR=0: hour_bcd = hour.
REQ-025 Counters SHALL never hold an illegal value (sec/min>59, hour>23) in any cycle.

Reset
REQ-026 On sys_rst_n low, asynchronously: time 00:00:00, state HOLD, synchronizer and edge-detector flops 0, sec_tick/day_wrap/set_err 0, set_ready 0 while in reset.
REQ-027 After deassertion, set_ready SHALL be 1 from the first edge; the first tick SHALL require a fresh rising edge of clk_1Hz_in (no spurious tick if the input is already high).
REQ-028 Reset mid-load SHALL abort the load; time returns to 00:00:00.

Structure
REQ-029 Shared package time_keeper_pkg SHALL hold SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, the FSM state encoding, and the binary-to-BCD function.
REQ-030 One sub-module mod_counter (parameter MAX, width W; ports clk, rst_n, inc, load, load_val; outputs value, wrap) SHALL be instantiated three times and chained via wrap.

Verification
REQ-031 Reset, run_en=1, 3 rising edges on clk_1Hz_in -> sec_bcd=0x03, 3 sec_tick pulses, each 3 cycles after its edge.
REQ-032 Load 23:59:58, run, 2 ticks -> 23:59:59 then 00:00:00, with day_wrap on the second tick and pm 1 -> 0.
REQ-033 Load hour=24 -> set_err pulse, time unchanged; load min=60 -> same.
REQ-034 run_en=0 with 5 ticks -> time constant; run_en=1 -> the next tick increments by exactly 1.
REQ-035 set_valid in the same cycle as the tick, loading 10:00:00 -> 10:00:00 held, no sec_tick.
REQ-036 TWELVE_HOUR=1, load 00:00:00 -> hour_bcd=0x12, pm=0; load 13:05:00 -> hour_bcd=0x01, pm=1.
